// File: rtl/retry_end_bounded_if.sv
// Retry channel between the retry end stage and the retry start stage.
//
// Handshake: the end stage raises valid with id when a faulty result needs
// re-execution. The start stage raises ready when it can take it. A transfer
// happens in every cycle where valid and ready are both 1. valid and id may
// depend combinationally on the end stage's inputs. ready must not depend
// combinationally on valid or id; the start stage registers the failed id.
//
// Signals:
//   id     element ID of the result to be retried
//   valid  retry request
//   ready  start stage accepts the request
//
// Modports:
//   master  end stage   (drives id/valid, samples ready)
//   slave   start stage (samples id/valid, drives ready)
interface retry_interface #(
  parameter int IDSize = 1
);
  logic [IDSize-1:0] id;
  logic              valid;
  logic              ready;

  modport master (output id, output valid, input ready);
  modport slave  (input id, input valid, output ready);
endinterface

// File: rtl/retry_end_bounded.sv
// Retry end stage with a bounded per-ID retry budget.
//
// Sits at the exit of a protected pipelined process. Good results are
// forwarded through a one-entry registered output stage. Faulty results are
// sent back over the retry channel until their ID has used up MaxRetries
// retries. After that, the result is forwarded with error_o set, so a
// persistent fault cannot livelock the pipeline.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   data_i, id_i         result and its element ID from the process
//   needs_retry_i        fault detected on this result
//   valid_i / ready_o    upstream handshake
//   data_o, error_o      registered result, budget-exhausted tag
//   valid_o / ready_i    downstream handshake
//   retry                retry channel to the start stage (master side)
//   retry_count_o        saturating count of retry handshakes
//   exhausted_count_o    saturating count of budget-exhausted results
module retry_end_bounded #(
  parameter type DataType   = logic,
  parameter int  IDSize     = 1,
  parameter int  MaxRetries = 3,
  parameter int  StatWidth  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  DataType               data_i,
  input  logic [IDSize-1:0]     id_i,
  input  logic                  needs_retry_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output DataType               data_o,
  output logic                  error_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  retry_interface.master        retry,
  output logic [StatWidth-1:0]  retry_count_o,
  output logic [StatWidth-1:0]  exhausted_count_o
);

  localparam int NumIds = 2 ** IDSize;
  // With MaxRetries=0 the counters never leave 0. They are kept one bit wide
  // so that no zero-width vectors appear.
  localparam int CntW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  logic [CntW-1:0] cnt_q [NumIds];

  logic    valid_q;
  DataType data_q;
  logic    err_q;

  logic [CntW-1:0] cur_cnt;
  logic            budget_left;
  logic            retry_req;
  logic            exhaust;
  logic            good;
  logic            fwd_req;
  logic            out_free;
  logic            retry_hs;
  logic            fwd_hs;

  // Input classification. Exactly one of retry_req / exhaust / good is set
  // when valid_i is 1.
  always_comb begin
    cur_cnt     = cnt_q[id_i];
    budget_left = (int'(cur_cnt) < MaxRetries);
    retry_req   = valid_i & needs_retry_i & budget_left;
    exhaust     = valid_i & needs_retry_i & ~budget_left;
    good        = valid_i & ~needs_retry_i;
    fwd_req     = good | exhaust;
    // The output register can take a new result when it is empty or is being
    // drained in this same cycle. This gives one result per cycle.
    out_free    = ~valid_q | ready_i;
    // A retry request waits only on the start stage. It does not depend on
    // the output register, so retries keep flowing while the output stalls.
    ready_o     = retry_req ? retry.ready : out_free;
    retry_hs    = retry_req & retry.ready;
    fwd_hs      = fwd_req & out_free;
  end

  assign retry.valid = retry_req;
  assign retry.id    = id_i;

  // Per-ID retry budget. Only the entry for id_i can change in a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) cnt_q[i] <= '0;
    end else if (retry_hs) begin
      cnt_q[id_i] <= cur_cnt + CntW'(1);
    end else if (fwd_hs) begin
      cnt_q[id_i] <= '0;
    end
  end

  // One-entry output register. A load takes priority over a drain, so a
  // load and a drain in the same cycle leave the register full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (fwd_hs) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      err_q   <= exhaust;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign error_o = err_q;

  // Saturating statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retry_count_o     <= '0;
      exhausted_count_o <= '0;
    end else begin
      if (retry_hs && (retry_count_o != '1))
        retry_count_o <= retry_count_o + StatWidth'(1);
      if (fwd_hs && exhaust && (exhausted_count_o != '1))
        exhausted_count_o <= exhausted_count_o + StatWidth'(1);
    end
  end

endmodule

// File: tb/tb_retry_end_bounded.sv
// Testbench for retry_end_bounded.
//
// Stimulus and checking:
// - The driver applies inputs 1 ns after each rising edge. At +2 ns it checks
//   the combinational outputs against a reference model. When a forward
//   handshake is expected, it pushes the expected {error, data} onto exp_q.
// - The reference model keeps per-ID retry usage and the statistics totals
//   as plain integers.
// - A monitor samples on each falling edge. It compares the presented output
//   with the head of exp_q and pops the head when the output is drained.
// - A second instance with MaxRetries=0 is checked with a short directed run.
module tb_retry_end_bounded;
  localparam int MR   = 3;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic [7:0]    data_i = '0;
  logic [1:0]    id_i = '0;
  logic          needs_retry_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [7:0]    data_o;
  logic          error_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [SW-1:0] retry_count_o;
  logic [SW-1:0] exhausted_count_o;
  retry_interface #(.IDSize(2)) rif ();

  retry_end_bounded #(
    .DataType(logic [7:0]), .IDSize(2), .MaxRetries(MR), .StatWidth(SW)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .data_i(data_i), .id_i(id_i), .needs_retry_i(needs_retry_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .error_o(error_o), .valid_o(valid_o), .ready_i(ready_i),
    .retry(rif.master),
    .retry_count_o(retry_count_o), .exhausted_count_o(exhausted_count_o)
  );

  // Instance with MaxRetries = 0 (never retry)
  logic [7:0]    z_data_i = '0;
  logic [1:0]    z_id_i = '0;
  logic          z_needs_retry_i = 1'b0;
  logic          z_valid_i = 1'b0;
  logic          z_ready_o;
  logic [7:0]    z_data_o;
  logic          z_error_o;
  logic          z_valid_o;
  logic          z_ready_i = 1'b1;
  logic [SW-1:0] z_retry_count_o;
  logic [SW-1:0] z_exhausted_count_o;
  retry_interface #(.IDSize(2)) z_rif ();

  retry_end_bounded #(
    .DataType(logic [7:0]), .IDSize(2), .MaxRetries(0), .StatWidth(SW)
  ) u_zero (
    .clk_i(clk), .rst_i(rst),
    .data_i(z_data_i), .id_i(z_id_i), .needs_retry_i(z_needs_retry_i),
    .valid_i(z_valid_i), .ready_o(z_ready_o),
    .data_o(z_data_o), .error_o(z_error_o), .valid_o(z_valid_o), .ready_i(z_ready_i),
    .retry(z_rif.master),
    .retry_count_o(z_retry_count_o), .exhausted_count_o(z_exhausted_count_o)
  );

  // Scoreboard and reference model
  logic [8:0] exp_q[$];   // {error, data}
  int used[4];            // retries spent per ID since its last forward
  int m_retries;
  int m_exhausted;
  int n_checks = 0;
  int n_pass = 0;

  initial begin
    rif.ready   = 1'b0;
    z_rif.ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) used[i] = 0;
    m_retries   = 0;
    m_exhausted = 0;
  endtask

  // One clock cycle of main-instance stimulus with model checks.
  task automatic cycle(input logic v, input logic [1:0] id, input logic [7:0] d,
                       input logic nr, input logic rr, input logic ri);
    bit occupied, is_retry, exp_ready;
    @(posedge clk);
    #1;
    valid_i = v; id_i = id; data_i = d; needs_retry_i = nr;
    rif.ready = rr; ready_i = ri;
    #1;
    occupied  = (exp_q.size() != 0);
    is_retry  = v && nr && (used[id] < MR);
    exp_ready = is_retry ? rr : (!occupied || ri);
    check("ready_o", ready_o, exp_ready);
    check("retry_valid", rif.valid, is_retry);
    if (is_retry) check("retry_id", rif.id, id);
    check("retry_count", retry_count_o, m_retries);
    check("exhausted_count", exhausted_count_o, m_exhausted);
    if (is_retry && rr) begin
      used[id]++;
      if (m_retries < SMAX) m_retries++;
    end else if (v && !is_retry && exp_ready) begin
      exp_q.push_back({nr, d});
      if (nr && m_exhausted < SMAX) m_exhausted++;
      used[id] = 0;
    end
  endtask

  // Monitor: compare the presented output with the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid_o) begin
        if (exp_q.size() == 0) begin
          check("valid_o_unexpected", valid_o, 0);
        end else begin
          check("data_o", data_o, exp_q[0][7:0]);
          check("error_o", error_o, exp_q[0][8]);
          if (ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] zd;
    logic       znr;
    int         zexh;
    model_reset();
    #3;
    check("reset_valid_o", valid_o, 0);
    check("reset_data_o", data_o, 0);
    check("reset_error_o", error_o, 0);
    check("reset_retry_count", retry_count_o, 0);
    check("reset_exh_count", exhausted_count_o, 0);
    #9 rst = 1'b0;

    // Good results with IDs 0,1,0
    cycle(1, 0, 8'h11, 0, 1, 1);
    cycle(1, 1, 8'h22, 0, 1, 1);
    cycle(1, 0, 8'h33, 0, 1, 1);
    // ID 1 faulty once, then good
    cycle(1, 1, 8'h44, 1, 1, 1);
    cycle(1, 1, 8'h45, 0, 1, 1);
    // ID 0 faulty four times: three retries, then exhaust
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'h50 + 8'(i), 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);
    check("exh_after_budget", exhausted_count_o, 1);
    check("retries_after_budget", retry_count_o, 4);
    // Retry held off for two cycles, then accepted
    cycle(1, 2, 8'h60, 1, 0, 1);
    cycle(1, 2, 8'h60, 1, 0, 1);
    cycle(1, 2, 8'h60, 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);
    check("retry_after_stall", retry_count_o, 5);
    // Output stalled: retry still completes, good result waits
    cycle(1, 3, 8'h70, 0, 1, 0);
    cycle(1, 3, 8'h71, 1, 1, 0);
    cycle(1, 1, 8'h72, 0, 1, 0);
    cycle(1, 1, 8'h72, 0, 1, 0);
    cycle(1, 1, 8'h72, 0, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Enough retries to pin the retry counter at all-ones
    for (int i = 0; i < 24; i++) cycle(1, 2'(i % 4), 8'(i), 1, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);
    check("retry_count_saturated", retry_count_o, SMAX);

    // Drain, then confirm the output is empty
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0, 1, 1);
    check("drained_valid_o", valid_o, 0);

    // Asynchronous reset while a result is held
    cycle(1, 0, 8'h99, 0, 1, 0);
    cycle(0, 0, 8'h00, 0, 1, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid_o", valid_o, 0);
    check("async_rst_retry_count", retry_count_o, 0);
    check("async_rst_exh_count", exhausted_count_o, 0);
    model_reset();
    valid_i = 1'b0;
    #4 rst = 1'b0;
    cycle(1, 1, 8'hA5, 0, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);
    cycle(0, 0, 8'h00, 0, 1, 1);

    // MaxRetries = 0: every faulty result goes out with the error tag
    zexh = 0;
    for (int i = 0; i < 6; i++) begin
      zd  = 8'($urandom_range(0, 255));
      znr = (i % 2) == 1;
      @(posedge clk);
      #1;
      z_valid_i = 1'b1; z_data_i = zd; z_needs_retry_i = znr; z_id_i = 2'(i % 4);
      #1;
      check("zero_ready_o", z_ready_o, 1);
      check("zero_retry_valid", z_rif.valid, 0);
      if (znr) zexh++;
      @(posedge clk);
      #1;
      z_valid_i = 1'b0;
      #1;
      check("zero_valid_o", z_valid_o, 1);
      check("zero_data_o", z_data_o, zd);
      check("zero_error_o", z_error_o, znr);
    end
    check("zero_retry_count", z_retry_count_o, 0);
    check("zero_exh_count", z_exhausted_count_o, zexh);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
